// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [3:0] SEL_ALL   = 4'hF;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data masters.
// MEM_ARB_RR_EN: alternate grants on a tie; otherwise data always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic flush,
    input  logic take,
    output logic grant_i,
    output logic grant_d
);

    logic i_ok;

    // A fetch raised in a flush cycle belongs to the squashed stream.
    assign i_ok = i_req & ~flush;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    always_comb begin
        grant_i = i_ok;
        grant_d = d_req;
        if (i_ok && d_req) begin
            grant_i = last_d;
            grant_d = ~last_d;
        end
    end

    // Starts as "data" so the first tie goes to the fetch port.
    always_ff @(posedge clk) begin
        if (reset)
            last_d <= 1'b1;
        else if (take && (grant_i || grant_d))
            last_d <= grant_d;
    end
`else
    logic unused_pick;

    assign grant_d     = d_req;
    assign grant_i     = i_ok & ~d_req;
    assign unused_pick = ^{clk, reset, take};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction-fetch and data ports onto one memory port, one
// transaction at a time. Optional round-robin via MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              flush,
    output logic              mem_access,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_st_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_w_data
);

    arb_state_t state, state_next;
    logic       kill;
    logic       grant_i, grant_d;

    mem_arb_pick u_pick (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .d_req   (d_req),
        .flush   (flush),
        .take    (state == IDLE),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign i_rdata = mem_w_data;
    assign d_rdata = mem_w_data;

    always_comb begin
        state_next = state;
        mem_access = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d)
                    state_next = DATA;
                else if (grant_i)
                    state_next = INST;
            end
            INST: begin
                mem_access = 1'b1;
                // A flush landing on the completion cycle still kills the fetch.
                i_ready = mem_ready & ~kill & ~flush & ~reset;
                if (mem_ready)
                    state_next = IDLE;
            end
            DATA: begin
                mem_access = 1'b1;
                d_ready = mem_ready & ~reset;
                if (mem_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            kill        <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_size    <= 2'd0;
            mem_sel     <= 4'd0;
            mem_st_data <= '0;
        end else begin
            state <= state_next;
            // Killed fetch still owns the port until the bridge finishes it.
            kill  <= (state == INST) && !mem_ready && (kill || flush);
            if (state == IDLE) begin
                if (grant_d) begin
                    mem_write   <= d_wr;
                    mem_addr    <= d_addr;
                    mem_size    <= d_size;
                    mem_sel     <= d_sel;
                    mem_st_data <= d_wdata;
                end else if (grant_i) begin
                    mem_write   <= 1'b0;
                    mem_addr    <= i_addr;
                    mem_size    <= SIZE_WORD;
                    mem_sel     <= SEL_ALL;
                    mem_st_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow
// MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_wr, flush, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_w_data;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic        i_ready, d_ready, mem_access, mem_write;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_st_data;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_sel(d_sel),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .flush(flush),
        .mem_access(mem_access), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
        .mem_ready(mem_ready), .mem_w_data(mem_w_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle into a granted transaction; completes it and
    // returns one cycle later (state back in IDLE).
    task automatic serve(input string tag, input logic is_inst, input logic [31:0] addr,
                         input logic wr, input logic [31:0] rdata);
        chk({tag, "_access"}, {31'd0, mem_access}, 32'd1);
        chk({tag, "_addr"}, mem_addr, addr);
        chk({tag, "_write"}, {31'd0, mem_write}, {31'd0, wr});
        mem_ready  = 1'b1;
        mem_w_data = rdata;
        #1;
        chk({tag, "_iready"}, {31'd0, i_ready}, {31'd0, is_inst});
        chk({tag, "_dready"}, {31'd0, d_ready}, {31'd0, ~is_inst});
        chk({tag, "_rdata"}, is_inst ? i_rdata : d_rdata, rdata);
        step();
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_req = 0; d_req = 0; d_wr = 0; flush = 0; mem_ready = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_w_data = 0; d_size = 0; d_sel = 0;
        do_reset();

        chk("rst_access", {31'd0, mem_access}, 32'd0);
        chk("rst_write", {31'd0, mem_write}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_size", {30'd0, mem_size}, 32'd0);
        chk("rst_sel", {28'd0, mem_sel}, 32'd0);
        chk("rst_stdata", mem_st_data, 32'd0);
        chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);

        // Fetch only, bridge answers 3 cycles after access goes high.
        i_req = 1; i_addr = 32'hBFC00000;
        step();
        chk("f_size", {30'd0, mem_size}, 32'd2);
        chk("f_sel", {28'd0, mem_sel}, 32'hF);
        chk("f_stdata", mem_st_data, 32'd0);
        step(); step();
        chk("f_wait_iready", {31'd0, i_ready}, 32'd0);
        serve("f", 1'b1, 32'hBFC00000, 1'b0, 32'h3C1D0000);
        i_req = 0;
        chk("f_gap", {31'd0, mem_access}, 32'd0);
        step();
        chk("f_idle", {31'd0, mem_access}, 32'd0);

        // Tie between fetch and store.
        do_reset();
        i_req = 1; i_addr = 32'h00400000;
        d_req = 1; d_wr = 1; d_addr = 32'h80001000; d_sel = 4'b0011;
        d_wdata = 32'h0000BEEF; d_size = 2'd2;
        step();
`ifdef MEM_ARB_RR_EN
        serve("rr_t1_inst", 1'b1, 32'h00400000, 1'b0, 32'h11111111);
        i_addr = 32'h00400004;
        chk("rr_gap1", {31'd0, mem_access}, 32'd0);
        step();
        chk("rr_t2_sel", {28'd0, mem_sel}, 32'h3);
        chk("rr_t2_stdata", mem_st_data, 32'h0000BEEF);
        serve("rr_t2_data", 1'b0, 32'h80001000, 1'b1, 32'h0);
        d_req = 0; d_wr = 0;
        chk("rr_gap2", {31'd0, mem_access}, 32'd0);
        step();
        serve("rr_inst2", 1'b1, 32'h00400004, 1'b0, 32'h22222222);
        i_req = 0;
`else
        chk("fx_sel", {28'd0, mem_sel}, 32'h3);
        chk("fx_stdata", mem_st_data, 32'h0000BEEF);
        serve("fx_data", 1'b0, 32'h80001000, 1'b1, 32'h0);
        d_req = 0; d_wr = 0;
        chk("fx_gap", {31'd0, mem_access}, 32'd0);
        step();
        chk("fx_inst_sel", {28'd0, mem_sel}, 32'hF);
        serve("fx_inst", 1'b1, 32'h00400000, 1'b0, 32'h11111111);
        i_req = 0;
`endif
        step();

        // Flush during a fetch: no i_ready, next fetch normal.
        i_req = 1; i_addr = 32'h00000100;
        step();
        chk("fl_access", {31'd0, mem_access}, 32'd1);
        flush = 1;
        step();
        flush = 0;
        step(); step();
        mem_ready = 1; mem_w_data = 32'hDEADDEAD;
        #1;
        chk("fl_killed_iready", {31'd0, i_ready}, 32'd0);
        step();
        mem_ready = 0; i_addr = 32'h00000200;
        chk("fl_idle", {31'd0, mem_access}, 32'd0);
        step();
        serve("fl_next", 1'b1, 32'h00000200, 1'b0, 32'h0A0B0C0D);
        // Fetch raised in a flush cycle is ignored; flush on the ready cycle kills.
        i_addr = 32'h00000300; flush = 1;
        step();
        chk("fl_idle_block", {31'd0, mem_access}, 32'd0);
        flush = 0;
        step();
        chk("fl_late_addr", mem_addr, 32'h00000300);
        mem_ready = 1; flush = 1;
        #1;
        chk("fl_late_iready", {31'd0, i_ready}, 32'd0);
        step();
        mem_ready = 0; flush = 0; i_req = 0;
        step();

        // Reset in the middle of a load.
        d_req = 1; d_wr = 0; d_addr = 32'h80002000; d_size = 2'd1; d_sel = 4'b1100;
        step();
        chk("rm_access", {31'd0, mem_access}, 32'd1);
        chk("rm_size", {30'd0, mem_size}, 32'd1);
        reset = 1; d_req = 0;
        step();
        reset = 0;
        chk("rm_access_low", {31'd0, mem_access}, 32'd0);
        chk("rm_outs", {mem_addr[27:0], mem_size, mem_write, |mem_st_data}, 32'd0);
        chk("rm_sel", {28'd0, mem_sel}, 32'd0);
        mem_ready = 1;
        #1;
        chk("rm_no_dready", {31'd0, d_ready}, 32'd0);
        step();
        mem_ready = 0;
        chk("rm_stay_idle", {31'd0, mem_access}, 32'd0);

        // Back-to-back loads: d_req held through the gap cycle.
        d_req = 1; d_addr = 32'h80003000; d_size = 2'd2; d_sel = 4'hF;
        step();
        serve("bb1", 1'b0, 32'h80003000, 1'b0, 32'h12345678);
        chk("bb_gap", {31'd0, mem_access}, 32'd0);
        step();
        d_req = 0;
        chk("bb2_access", {31'd0, mem_access}, 32'd1);
        step();
        serve("bb2", 1'b0, 32'h80003000, 1'b0, 32'h9ABCDEF0);
        chk("bb_end", {31'd0, mem_access}, 32'd0);
        step();
        chk("bb_idle", {31'd0, mem_access}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master request arbiter sitting directly upstream of the AXI bridge: merges the instruction-fetch port and the data-access port of the CPU core onto the single cache-style memory port (`mem_*`) that the AXI bridge consumes. Grants one transaction at a time, holds the granted request stable until the bridge reports completion, and returns the read data and completion pulse to the owning master. Pipeline flush discards in-flight instruction fetches without breaking the downstream handshake.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous active-high reset
- `i_req`  in  1  instruction fetch request, held until `i_ready`
- `i_addr`  in  ADDR_W  fetch address
- `i_ready`  out  1  one-cycle completion pulse to fetch master
- `i_rdata`  out  DATA_W  fetch data, valid when `i_ready`
- `d_req`  in  1  data request, held until `d_ready`
- `d_wr`  in  1  1 = store, 0 = load
- `d_size`  in  2  0 byte, 1 half, 2 word
- `d_sel`  in  4  byte strobes for stores
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ready`  out  1  one-cycle completion pulse to data master
- `d_rdata`  out  DATA_W  load data, valid when `d_ready`
- `flush`  in  1  pipeline flush
- `mem_access`, `mem_write`  out  1  downstream request / write flag
- `mem_addr`  out  ADDR_W; `mem_size`  out  2; `mem_sel`  out  4; `mem_st_data`  out  DATA_W
- `mem_ready`  in  1  downstream completion pulse
- `mem_w_data`  in  DATA_W  downstream read data

## Operation
- States: IDLE, INST, DATA. Reset -> IDLE.
- IDLE: evaluate requests; `d_req` wins over `i_req` (data is the older instruction). `i_req` ignored in a cycle with `flush` high. On grant, register addr/size/sel/wdata/write into `mem_*` and enter INST or DATA.
- Instruction grant drives `mem_write`=0, `mem_size`=2, `mem_sel`=4'b1111, `mem_st_data`=0.
- INST/DATA: `mem_*` held constant; `mem_access`=1. On `mem_ready`: pulse owner's ready, return to IDLE.
- `i_rdata`/`d_rdata` = `mem_w_data` combinationally (don't-care when ready low).
- Flush: `flush` high in INST (including the `mem_ready` cycle) sets kill flag; killed fetch still waits for `mem_ready`, `i_ready` is suppressed. Kill flag clears on return to IDLE. DATA transactions never affected by flush.
- `mem_ready` outside INST/DATA ignored.

## Timing
- Reset values: `mem_access`=0, `mem_write`=0, `mem_addr`=0, `mem_size`=0, `mem_sel`=0, `mem_st_data`=0, `i_ready`=0, `d_ready`=0, kill=0.
- Request seen in IDLE at cycle N -> `mem_access` high at N+1.
- `mem_ready` at cycle M -> owner ready at M (combinational), `mem_access` low at M+1 (IDLE).
- Mandatory one-cycle `mem_access`=0 gap between transactions; next access earliest M+2.
- Masters deassert or replace request in cycle after their ready; a request still high in IDLE is a new transaction.
- Reset mid-transaction: IDLE next cycle, `mem_access` low, no ready pulse.

## Configuration
- `MEM_ARB_RR_EN` defined: when both `i_req` and `d_req` pending in IDLE, grant the master that did not receive the previous grant (last-grant bit reset to "data", so first tie goes to instruction). Undefined: fixed data priority, no last-grant register.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, INST, DATA), `SIZE_WORD`=2'd2, `SEL_ALL`=4'hF.
- Sub-module `mem_arb_pick`: combinational/registered grant selection (fixed or round-robin under `MEM_ARB_RR_EN`); main block holds FSM and request registers.

## Test plan
- Fetch only: `i_req`, `i_addr`=0xBFC00000; `mem_ready` 3 cycles after access, `mem_w_data`=0x3C1D0000 -> `mem_access` high at N+1, `mem_size`=2, `mem_sel`=F, `i_ready` pulse with `i_rdata`=0x3C1D0000.
- Simultaneous `i_req` + `d_req` store (addr 0x80001000, sel 4'b0011, data 0x0000BEEF) -> DATA first with `mem_write`=1; fetch granted after `mem_ready` + 1 gap cycle (fixed priority).
- Same as above with `MEM_ARB_RR_EN` -> fetch first, then store; second tie -> data.
- Flush during INST: `flush` at access+1, `mem_ready` at access+4 -> no `i_ready`, FSM returns IDLE, next fetch completes normally.
- `reset` asserted mid-DATA -> `mem_access`=0 next cycle, no `d_ready`, all outputs at reset values.
- Back-to-back loads with `d_req` held high one extra cycle -> two transactions, `mem_access` low exactly one cycle between them.
